// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/select op encodings, IEEE-754 single constants
// and the operand decode record passed from fcmp_decode into the pipeline.
package fpu_pkg;

    typedef enum logic [2:0] {
        FCMP_LT   = 3'd0,
        FCMP_LE   = 3'd1,
        FCMP_EQ   = 3'd2,
        FCMP_GT   = 3'd3,
        FCMP_GE   = 3'd4,
        FCMP_MIN  = 3'd5,
        FCMP_MAX  = 3'd6,
        FCMP_RSVD = 3'd7
    } fcmp_op_e;

    localparam logic [31:0] F_CANON_NAN = 32'h7FC0_0000;
    localparam logic [7:0]  F_EXP_ONES  = 8'hFF;
    localparam logic [31:0] F_NEG_ZERO  = 32'h8000_0000;
    localparam logic [31:0] F_POS_ZERO  = 32'h0000_0000;

    typedef struct packed {
        logic abs_lt;
        logic abs_eq;
        logic nan1;
        logic nan2;
        logic both_zero;
    } fcmp_dec_t;

    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == F_EXP_ONES) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Request/response bundle of the float compare/select unit.
// Both sides use valid/ready: a beat transfers on the rising edge where valid & ready
// are both high; the sender holds its fields stable while valid=1 and ready=0.
interface fcmp_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_flag;
    logic [31:0]      out_value;
    logic             out_unord;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        input  in_ready, out_valid, out_flag, out_value, out_unord, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
        output in_ready, out_valid, out_flag, out_value, out_unord, out_tag
    );
endinterface

// File: rtl/fcmp_decode.sv
// Combinational operand decode for float compares: magnitude order, NaN and
// double-zero detection. Shared with the branch unit.
module fcmp_decode
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output fcmp_dec_t   dec
);
    assign dec.abs_lt    = x1[30:0] < x2[30:0];
    assign dec.abs_eq    = x1[30:0] == x2[30:0];
    assign dec.nan1      = f_is_nan(x1);
    assign dec.nan2      = f_is_nan(x2);
    assign dec.both_zero = (x1[30:0] == 31'd0) && (x2[30:0] == 31'd0);
endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage float compare/select: s1 registers operands plus decode, s2 holds the
// final result. One op per cycle, two cycles of latency, tag passed through.
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    fcmp_pipe_if.slave  bus
);
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_x1;
    logic [31:0]      s1_x2;
    fcmp_dec_t        s1_dec;
    fcmp_dec_t        dec_d;

    logic             s2_valid;
    logic             flag_q;
    logic [31:0]      value_q;
    logic             unord_q;
    logic [TAG_W-1:0] tag_q;

    logic s2_adv, s1_adv, accept;
    logic unord, lt, gt, eq, sgn1, sgn2;
    logic flag_d;
    logic [31:0] value_d;

    // in_ready looks straight through to out_ready so a full pipe can accept and
    // retire in the same cycle without a bubble.
    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign accept       = bus.in_valid & s1_adv;
    assign bus.in_ready = s1_adv;

    fcmp_decode u_decode (
        .x1  (bus.in_x1),
        .x2  (bus.in_x2),
        .dec (dec_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= bus.in_op;
            s1_tag <= bus.in_tag;
            s1_x1  <= bus.in_x1;
            s1_x2  <= bus.in_x2;
            s1_dec <= dec_d;
        end
    end

    // Sign-magnitude ordering; both negative reverses the magnitude order.
    assign sgn1  = s1_x1[31];
    assign sgn2  = s1_x2[31];
    assign unord = s1_dec.nan1 | s1_dec.nan2;
    assign lt = ~unord & ~s1_dec.both_zero &
                ((sgn1 & ~sgn2) |
                 (~sgn1 & ~sgn2 & s1_dec.abs_lt) |
                 (sgn1 & sgn2 & ~s1_dec.abs_lt & ~s1_dec.abs_eq));
    assign gt = ~unord & ~s1_dec.both_zero &
                ((sgn2 & ~sgn1) |
                 (~sgn1 & ~sgn2 & ~s1_dec.abs_lt & ~s1_dec.abs_eq) |
                 (sgn1 & sgn2 & s1_dec.abs_lt));
    assign eq = ~unord & (s1_dec.both_zero | (s1_x1 == s1_x2));

    always_comb begin
        flag_d  = 1'b0;
        value_d = 32'd0;
        case (fcmp_op_e'(s1_op))
            FCMP_LT: flag_d = lt;
            FCMP_LE: flag_d = lt | eq;
            FCMP_EQ: flag_d = eq;
            FCMP_GT: flag_d = gt;
            FCMP_GE: flag_d = gt | eq;
            FCMP_MIN, FCMP_MAX: begin
                if (s1_dec.nan1 & s1_dec.nan2) begin
                    value_d = F_CANON_NAN;
                end else if (s1_dec.nan1) begin
                    value_d = s1_x2;
                end else if (s1_dec.nan2) begin
                    value_d = s1_x1;
                end else if (s1_dec.both_zero) begin
                    // MIN prefers -0, MAX prefers +0
                    if (fcmp_op_e'(s1_op) == FCMP_MIN) begin
                        value_d = (sgn1 | sgn2) ? F_NEG_ZERO : F_POS_ZERO;
                    end else begin
                        value_d = (~sgn1 | ~sgn2) ? F_POS_ZERO : F_NEG_ZERO;
                    end
                end else if (fcmp_op_e'(s1_op) == FCMP_MIN) begin
                    value_d = lt ? s1_x1 : s1_x2;
                end else begin
                    value_d = gt ? s1_x1 : s1_x2;
                end
            end
            default: begin
                flag_d  = 1'b0;
                value_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            flag_q   <= 1'b0;
            value_q  <= 32'd0;
            unord_q  <= 1'b0;
            tag_q    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                flag_q  <= flag_d;
                value_q <= value_d;
                unord_q <= unord;
                tag_q   <= s1_tag;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_flag  = flag_q;
    assign bus.out_value = value_q;
    assign bus.out_unord = unord_q;
    assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed vectors, backpressure, async reset and a random
// mix checked against an ordered-key reference model through an expected queue.
module tb_fcmp_pipe;
    import fpu_pkg::*;

    localparam int TAG_W = 5;
    localparam int W     = 1 + 32 + 1 + TAG_W;

    logic clk;
    logic rst;
    int   tests;
    int   errors;
    logic [W-1:0] exp_q[$];
    bit   rand_ready;

    fcmp_pipe_if #(.TAG_W(TAG_W)) bus ();

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d errors=%0d", tests, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / model ----------------
    function automatic logic [W-1:0] pk(input logic f, input logic [31:0] v,
                                        input logic u, input logic [TAG_W-1:0] t);
        return {f, v, u, t};
    endfunction

    function automatic logic is_nan_m(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps a non-NaN float onto a signed integer line; +0 and -0 both land on 0.
    function automatic logic signed [32:0] key(input logic [31:0] x);
        logic signed [32:0] k;
        k = {2'b00, x[30:0]};
        if (x[31]) k = -k;
        return k;
    endfunction

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        logic u, l, g, e, f;
        logic [31:0] v;
        logic signed [32:0] ka, kb;
        u  = is_nan_m(a) || is_nan_m(b);
        ka = key(a);
        kb = key(b);
        l  = !u && (ka < kb);
        g  = !u && (ka > kb);
        e  = !u && (ka == kb);
        f  = 1'b0;
        v  = 32'd0;
        case (op)
            3'd0: f = l;
            3'd1: f = l || e;
            3'd2: f = e;
            3'd3: f = g;
            3'd4: f = g || e;
            3'd5, 3'd6: begin
                if (is_nan_m(a) && is_nan_m(b)) v = 32'h7FC00000;
                else if (is_nan_m(a)) v = b;
                else if (is_nan_m(b)) v = a;
                else if (ka < kb) v = (op == 3'd5) ? a : b;
                else if (ka > kb) v = (op == 3'd5) ? b : a;
                else if (ka == 0) begin
                    if (op == 3'd5) v = (a[31] || b[31]) ? 32'h80000000 : 32'h0;
                    else            v = (!a[31] || !b[31]) ? 32'h0 : 32'h80000000;
                end else v = b;
            end
            default: ;
        endcase
        return pk(f, v, u, t);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic [W-1:0] e);
        int  budget;
        bit  done;
        budget       = 300;
        done         = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_x1    = a;
        bus.in_x2    = b;
        bus.in_tag   = t;
        while (!done && budget > 0) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
            budget--;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            tests++;
            errors++;
            $display("FAIL send_timeout: tag %0d not accepted, in_ready=%b", t, bus.in_ready);
        end
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 500;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1;
        check(name, W'(exp_q.size()), W'(0));
    endtask

    function automatic logic [31:0] pick_operand(input logic [31:0] other);
        logic [31:0] specials[10];
        int sel;
        specials = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001,
                     32'hFFC12345, 32'h00000001, 32'h807FFFFF, 32'h3F800000, 32'hBF800000};
        sel = $urandom_range(0, 13);
        if (sel < 10) return specials[sel];
        if (sel == 10) return other;
        if (sel == 11) return other ^ 32'h80000000;
        return $urandom();
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic [W-1:0] prev_out;
    bit           prev_stall;

    always @(negedge clk) begin
        logic [W-1:0] cur;
        logic [W-1:0] e;
        cur = pk(bus.out_flag, bus.out_value, bus.out_unord, bus.out_tag);
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!bus.out_valid || cur !== prev_out) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%b %h, held %h", bus.out_valid, cur, prev_out);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h, expected nothing", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL result: got %h, expected %h (flag,value,unord,tag)", cur, e);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = cur;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        logic [31:0] v;
        logic        u;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs = '{
            '{3'd0, 32'h3F800000, 32'h40000000, 1'b1, 32'h0,        1'b0}, // LT 1<2
            '{3'd3, 32'h3F800000, 32'h40000000, 1'b0, 32'h0,        1'b0}, // GT 1>2
            '{3'd0, 32'hBF800000, 32'hC0000000, 1'b0, 32'h0,        1'b0}, // LT -1<-2
            '{3'd4, 32'hBF800000, 32'hC0000000, 1'b1, 32'h0,        1'b0}, // GE -1>=-2
            '{3'd2, 32'h80000000, 32'h00000000, 1'b1, 32'h0,        1'b0}, // EQ -0==+0
            '{3'd0, 32'h80000000, 32'h00000000, 1'b0, 32'h0,        1'b0}, // LT -0<+0
            '{3'd5, 32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0}, // MIN(+0,-0)
            '{3'd6, 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0}, // MAX(+0,-0)
            '{3'd2, 32'h7FC00001, 32'h7FC00001, 1'b0, 32'h0,        1'b1}, // EQ NaN
            '{3'd5, 32'h7FC00001, 32'h40000000, 1'b0, 32'h40000000, 1'b1}, // MIN(NaN,2)
            '{3'd6, 32'h7FC00001, 32'hFFC00002, 1'b0, 32'h7FC00000, 1'b1}, // MAX(NaN,NaN)
            '{3'd7, 32'h3F800000, 32'h7FC00001, 1'b0, 32'h0,        1'b1}, // reserved
            '{3'd1, 32'h40000000, 32'h40000000, 1'b1, 32'h0,        1'b0}, // LE 2<=2
            '{3'd6, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0}, // MAX(inf,1)
            '{3'd5, 32'h00000001, 32'h80000001, 1'b0, 32'h80000001, 1'b0}, // MIN denorms
            '{3'd0, 32'hFF800000, 32'h00000000, 1'b1, 32'h0,        1'b0}  // LT -inf<0
        };
    end

    // ---------------- main sequence ----------------
    initial begin
        tests         = 0;
        errors        = 0;
        rand_ready    = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_x1     = 32'd0;
        bus.in_x2     = 32'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_fields", pk(bus.out_flag, bus.out_value, bus.out_unord, bus.out_tag), W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // latency of the first op
        send(vecs[0].op, vecs[0].a, vecs[0].b, 5'd3, pk(vecs[0].f, vecs[0].v, vecs[0].u, 5'd3));
        @(negedge clk);
        check("latency_cycle1", W'(bus.out_valid), W'(0));
        @(negedge clk);
        check("latency_cycle2", W'(bus.out_valid), W'(1));
        @(posedge clk);
        #1;

        for (int i = 1; i < 16; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, 5'(3 + i), pk(vecs[i].f, vecs[i].v, vecs[i].u, 5'(3 + i)));
        wait_drain("directed_drain");

        // backpressure: two ops flow, then the output stalls with 6 more queued
        for (int i = 0; i < 2; i++)
            send(3'(i), 32'h3F800000, 32'h40000000, 5'(16 + i), model(3'(i), 32'h3F800000, 32'h40000000, 5'(16 + i)));
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 2; i < 8; i++)
                    send(3'(i - 2), 32'hC0400000, 32'h40400000, 5'(16 + i),
                         model(3'(i - 2), 32'hC0400000, 32'h40400000, 5'(16 + i)));
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", W'(bus.in_ready), W'(0));
                check("stall_out_valid", W'(bus.out_valid), W'(1));
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");

        // async reset with both stages full
        bus.out_ready = 1'b0;
        send(3'd0, 32'h3F800000, 32'h40000000, 5'd30, model(3'd0, 32'h3F800000, 32'h40000000, 5'd30));
        send(3'd3, 32'h3F800000, 32'h40000000, 5'd31, model(3'd3, 32'h3F800000, 32'h40000000, 5'd31));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", W'(bus.out_valid), W'(0));
        exp_q.delete();
        @(posedge clk);
        #3;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", W'(bus.out_valid), W'(0));
        end
        @(posedge clk);
        #1;
        send(3'd5, 32'hC0000000, 32'h3F800000, 5'd9, pk(1'b0, 32'hC0000000, 1'b0, 5'd9));
        @(negedge clk);
        check("post_rst_latency1", W'(bus.out_valid), W'(0));
        @(negedge clk);
        check("post_rst_latency2", W'(bus.out_valid), W'(1));
        @(posedge clk);
        #1;
        wait_drain("post_rst_drain");

        // random mix with random out_ready
        rand_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick_operand($urandom());
            b  = pick_operand(a);
            send(op, a, b, 5'(i), model(op, a, b, 5'(i)));
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_drain("random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Two-stage pipelined single-precision float compare / select unit with a valid/ready handshake, for the FPU issue path.
- Answers both ordering directions (less and greater) plus equality, and produces min/max values.
- IEEE-correct for signed zero and NaN: ±0 compare equal, NaN is unordered.
- Carries an opaque tag through the pipeline so the scheduler can match results to the ops that produced them.

Parameters:
TAG_W, 5, width of the pass-through tag (destination register index)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input operation valid
in_ready  out  1  unit can accept an operation this cycle
in_op  in  3  0 LT, 1 LE, 2 EQ, 3 GT, 4 GE, 5 MIN, 6 MAX, 7 reserved
in_x1  in  32  operand 1, IEEE-754 single
in_x2  in  32  operand 2, IEEE-754 single
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_flag  out  1  boolean result (LT..GE); 0 for MIN/MAX/reserved
out_value  out  32  selected value (MIN/MAX); 0 for other ops
out_unord  out  1  at least one operand is NaN
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_flag=0, out_value=0, out_unord=0, out_tag=0. Data registers need no reset. An op in flight during reset is discarded; nothing emerges after rst deasserts until a new accept.
- Handshake:
  - Accept when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Out fields stay stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage s1 registers op, tag, operands and the decode: abs_lt = x1[30:0] < x2[30:0], abs_eq, nan1/nan2 (exp=0xFF, mantissa≠0), both_zero (both abs fields = 0).
  - Stage s2 holds the final outputs; out_valid = s2_valid.
  - Latency is exactly 2 cycles from accept to out_valid with no stall.
  - Throughput is 1 op/cycle.
- Stall: s2 advances when ~s2_valid | out_ready. s1 advances when ~s1_valid | s2 advances. in_ready = ~s1_valid | s2 advances (combinational from out_ready; no skid buffer).
- Ordering:
  - lt = ~unord & ~both_zero & ((s1 & ~s2) | (~s1 & ~s2 & abs_lt) | (s1 & s2 & ~abs_lt & ~abs_eq)).
  - eq = ~unord & (both_zero | (x1 == x2)).
  - gt is lt with operands swapped.
  - LE = lt|eq, GE = gt|eq.
  - -0 vs +0: lt=0, eq=1.
- NaN:
  - out_unord = nan1|nan2.
  - All boolean ops give 0 when unordered, including EQ(NaN,NaN)=0.
  - MIN/MAX return the non-NaN operand; both NaN → 0x7FC00000.
  - Infinities compare normally. Denormals are compared as bit patterns (no flush).
- MIN/MAX:
  - MIN returns x1 if lt else x2; MAX returns x1 if gt else x2.
  - Both zero: MIN returns -0 (0x80000000) if either operand is -0; MAX returns +0 if either is +0.
  - Equal non-zero operands return x2 (bit-identical anyway).
- Reserved op 7: out_flag=0, out_value=0, out_unord is computed normally, and the op still consumes a slot and returns its tag.
- Simultaneous accept and retire in the same cycle with both stages full is legal; no bubble is inserted.

Decomposition:
- Package fpu_pkg:
  - op encodings FCMP_LT..FCMP_MAX;
  - constants F_CANON_NAN = 32'h7FC00000, F_EXP_ONES = 8'hFF;
  - a function f_is_nan(x).
- One sub-module, fcmp_decode: combinational abs_lt / abs_eq / nan / zero decode feeding s1, reusable by the branch unit.

Test Plan:
- LT(0x3F800000 1.0, 0x40000000 2.0) tag=3, out_ready=1 → out_valid exactly 2 cycles after accept, flag=1, unord=0, tag=3. GT on the same operands → flag=0.
- LT(0xBF800000 -1.0, 0xC0000000 -2.0) → flag=0. GE on the same pair → flag=1. EQ(0x80000000, 0x00000000) → flag=1. LT(-0,+0) → flag=0. MIN(+0,-0) → 0x80000000. MAX → 0x00000000.
- EQ(0x7FC00001, 0x7FC00001) → flag=0, unord=1. MIN(0x7FC00001, 0x40000000) → value 0x40000000. MAX(NaN, NaN) → value 0x7FC00000.
- Back-to-back 8 ops with out_ready held 0 after the first 2 → in_ready drops once both stages are full. Outputs remain stable. Releasing out_ready drains all 8 in order by tag with no loss or duplication.
- Random out_ready toggling over 1000 random ops (including ±inf, denormals, NaN) vs a reference model → all flags, values and tags match in order.
- Assert rst for 1 cycle with both stages full → out_valid=0 immediately (async). First output after reset comes 2 cycles after the next accept.
